grf_scoreboard: RTL and testbench
=================================

Name: grf_scoreboard

Overview:
- Parametrised general register file for the pipelined CPU; successor of the single-cycle GRF.
- Configurable data width, address width and number of read ports.
- Register 0 is hardwired to zero.
- Adds a per-register in-flight write counter (scoreboard) so decode can detect RAW hazards; optional write-to-read bypass.

Parameters:
- DATA_W, 32, register data width in bits
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of independent read ports (>=1)
- PEND_W, 2, width of each per-register in-flight counter; max count = 2**PEND_W-1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- rd_busy  output  NUM_RD  port k: register at rd_addr[k] has a nonzero in-flight count
- wr_en  input  1  writeback enable
- wr_addr  input  ADDR_W  writeback address
- wr_data  input  DATA_W  writeback data
- iss_en  input  1  issue request: an instruction will later write iss_addr
- iss_addr  input  ADDR_W  destination register of the issued instruction
- iss_ok  output  1  issue accepted this cycle (combinational)

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset:
  - on a posedge with reset=1, all DEPTH registers := 0 and all counters := 0.
  - wr_en and iss_en are ignored that cycle.
  - Reads stay combinational; after that edge every rd_data = 0 and every rd_busy = 0.
- Reads:
  - combinational, zero latency.
  - rd_addr = 0 always returns 0 with busy = 0.
- Write:
  - on posedge with wr_en=1 and wr_addr != 0, reg[wr_addr] := wr_data.
  - wr_addr = 0 is ignored: no data change, no counter change.
- Counters (cnt[a], PEND_W bits each, cnt[0] fixed at 0):
  - inc = iss_en && iss_ok && iss_addr == a && a != 0
  - dec = wr_en && wr_addr == a && a != 0 && cnt[a] != 0
  - inc only: +1. dec only: -1. Both: unchanged. Neither: unchanged.
  - Write with cnt = 0 still updates data; counter stays 0 (no underflow).
- iss_ok:
  - = !(iss_en && iss_addr != 0 && cnt[iss_addr] == MAX && !(wr_en && wr_addr == iss_addr)).
  - iss_addr = 0 is always ok and has no effect.
  - A refused issue (iss_ok = 0) changes nothing.
  - iss_ok = 1 when iss_en = 0.
- rd_busy[k] = (cnt[rd_addr[k]] != 0), from registered state only. The same-cycle issue/write does not affect it.
- Reset has priority over all activity. Reset mid-operation discards all pending counts.
- No X on outputs after the first reset.

Optional Feature:
- Macro: GRF_BYPASS_EN.
- Defined:
  - if wr_en && wr_addr != 0 && wr_addr == rd_addr[k] (and reset = 0), rd_data[k] = wr_data in the same cycle (write-through).
  - rd_busy[k] = (cnt[rd_addr[k]] != 0) && !(cnt == 1 && wr_en && wr_addr == rd_addr[k]), i.e. the last pending write is being delivered.
- Undefined: rd_data[k] returns the stored value (old data until the edge); rd_busy unchanged from the base rule.

Test Plan:
- Reset then read all 32 regs on both ports -> all rd_data = 0, rd_busy = 0; write r0 = 0xDEADBEEF -> r0 still reads 0.
- Write r5 = 0x12345678, next cycle rd_addr0 = 5 -> 0x12345678. Same-cycle read of r5 while writing 0xAAAA5555 -> 0x12345678 without GRF_BYPASS_EN, 0xAAAA5555 with it.
- Issue r7 three times (PEND_W = 2) -> cnt = 3, rd_busy = 1. Fourth issue alone -> iss_ok = 0, count stays 3. Fourth issue with concurrent write to r7 -> iss_ok = 1, count stays 3. Three more writes -> busy clears after the third.
- Write r9 with cnt = 0 -> data updated, rd_busy stays 0; subsequent single issue -> busy = 1 next cycle.
- Issue r3 and r4, assert reset one cycle with wr_en = 1, wr_addr = 3, wr_data = 0xFFFFFFFF -> r3 = 0, all busy = 0, iss_ok = 1.
- NUM_RD = 3, DATA_W = 16 build: three ports read r1, r2, r1 after writes 0x1111, 0x2222 -> 0x1111, 0x2222, 0x1111.

Source files
------------

// File: rtl/grf_scoreboard.sv
// General register file with a per-register in-flight write scoreboard for RAW hazard detection.
// Define GRF_BYPASS_EN to make a same-cycle writeback visible on the read ports (write-through).
module grf_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int PEND_W = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic                       iss_ok
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [PEND_W-1:0] cnt  [DEPTH];
    logic [DEPTH-1:0]  inc_vec;
    logic [DEPTH-1:0]  dec_vec;

    // A saturated counter can still take a new issue if a write retires one slot this cycle.
    always_comb begin
        iss_ok = !(iss_en && (iss_addr != '0) && (cnt[iss_addr] == CNT_MAX)
                   && !(wr_en && (wr_addr == iss_addr)));
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int a = 1; a < DEPTH; a++) begin
            inc_vec[a] = iss_en && iss_ok && (iss_addr == ADDR_W'(a));
            dec_vec[a] = wr_en && (wr_addr == ADDR_W'(a)) && (cnt[a] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < DEPTH; a++) begin
                regs[a] <= '0;
                cnt[a]  <= '0;
            end
        end else begin
            regs[0] <= '0;
            cnt[0]  <= '0;
            for (int a = 1; a < DEPTH; a++) begin
                if (wr_en && (wr_addr == ADDR_W'(a))) begin
                    regs[a] <= wr_data;
                end
                if (inc_vec[a] && !dec_vec[a]) begin
                    cnt[a] <= cnt[a] + CNT_ONE;
                end else if (dec_vec[a] && !inc_vec[a]) begin
                    cnt[a] <= cnt[a] - CNT_ONE;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef GRF_BYPASS_EN
        logic hit;
        assign hit = wr_en && !reset && (wr_addr != '0) && (wr_addr == ra);
        assign rd_data[k*DATA_W +: DATA_W] = hit ? wr_data : regs[ra];
        // Busy drops early when the last outstanding write is being delivered right now.
        assign rd_busy[k] = (cnt[ra] != '0)
                            && !((cnt[ra] == CNT_ONE) && wr_en && (wr_addr == ra));
`else
        assign rd_data[k*DATA_W +: DATA_W] = regs[ra];
        assign rd_busy[k] = (cnt[ra] != '0);
`endif
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Bench for grf_scoreboard: queue-free array model checked every cycle plus literal pins.
module tb_grf_scoreboard;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        iss_ok;

    logic [14:0] rd_addr2;
    logic [47:0] rd_data2;
    logic [2:0]  rd_busy2;
    logic        wr_en2;
    logic [4:0]  wr_addr2;
    logic [15:0] wr_data2;
    logic        iss_ok2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_reg [32];
    int          m_cnt [32];
    bit          m_valid = 1'b0;

    always #5 clk = ~clk;

    grf_scoreboard dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ok(iss_ok)
    );

    grf_scoreboard #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3), .PEND_W(2)) dut3 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .iss_en(1'b0), .iss_addr(5'd0), .iss_ok(iss_ok2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_iss_ok();
        if (!iss_en || iss_addr == 5'd0) return 1'b1;
        if (m_cnt[iss_addr] < MAXC) return 1'b1;
        return wr_en && (wr_addr == iss_addr);
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
`ifdef GRF_BYPASS_EN
        if (!reset && wr_en && wr_addr != 5'd0 && wr_addr == a) return wr_data;
`endif
        return (a == 5'd0) ? 32'd0 : m_reg[a];
    endfunction

    function automatic logic model_busy(input logic [4:0] a);
        if (a == 5'd0 || m_cnt[a] == 0) return 1'b0;
`ifdef GRF_BYPASS_EN
        if (m_cnt[a] == 1 && wr_en && wr_addr == a) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Model state advances on the same edge the DUT samples.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] <= 32'd0;
                m_cnt[i] <= 0;
            end
            m_valid <= 1'b1;
        end else if (m_valid) begin
            if (wr_en && wr_addr != 5'd0) m_reg[wr_addr] <= wr_data;
            for (int a = 1; a < 32; a++) begin
                m_cnt[a] <= m_cnt[a]
                    + ((iss_en && model_iss_ok() && iss_addr == 5'(a)) ? 1 : 0)
                    - ((wr_en && wr_addr == 5'(a) && m_cnt[a] > 0) ? 1 : 0);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("iss_ok", {31'd0, iss_ok}, {31'd0, model_iss_ok()});
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rd_data%0d", k), rd_data[k*32 +: 32], model_rd(rd_addr[k*5 +: 5]));
                chk($sformatf("rd_busy%0d", k), {31'd0, rd_busy[k]},
                    {31'd0, model_busy(rd_addr[k*5 +: 5])});
            end
        end
    end

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick_addr(input int r);
        case (r)
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            default: return 5'd7;
        endcase
    endfunction

    initial begin
        reset = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0;
        rd_addr2 = '0; wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0;
        edge_step();
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'(31 - i), 5'(i)};
            settle();
            chk("reset_data0", rd_data[31:0], 32'd0);
            chk("reset_data1", rd_data[63:32], 32'd0);
            chk("reset_busy", {30'd0, rd_busy}, 32'd0);
            edge_step();
        end

        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF; rd_addr = '0;
        edge_step();
        wr_en = 1'b0;
        settle();
        chk("r0_zero", rd_data[31:0], 32'd0);
        edge_step();

        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678;
        edge_step();
        wr_en = 1'b0; rd_addr = {5'd0, 5'd5};
        settle();
        chk("r5_read", rd_data[31:0], 32'h12345678);
        edge_step();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hAAAA5555;
        settle();
`ifdef GRF_BYPASS_EN
        chk("r5_same_cycle", rd_data[31:0], 32'hAAAA5555);
`else
        chk("r5_same_cycle", rd_data[31:0], 32'h12345678);
`endif
        edge_step();
        wr_en = 1'b0;
        settle();
        chk("r5_after", rd_data[31:0], 32'hAAAA5555);
        edge_step();

        iss_en = 1'b1; iss_addr = 5'd7; rd_addr = {5'd0, 5'd7};
        for (int j = 0; j < 3; j++) begin
            settle();
            chk("r7_issue_ok", {31'd0, iss_ok}, 32'd1);
            edge_step();
        end
        iss_en = 1'b0;
        settle();
        chk("r7_busy", {31'd0, rd_busy[0]}, 32'd1);
        iss_en = 1'b1;
        #1;
        chk("r7_full_refused", {31'd0, iss_ok}, 32'd0);
        edge_step();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000077;
        settle();
        chk("r7_full_with_wr", {31'd0, iss_ok}, 32'd1);
        edge_step();
        iss_en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            settle();
`ifdef GRF_BYPASS_EN
            chk("r7_drain_busy", {31'd0, rd_busy[0]}, (j == 2) ? 32'd0 : 32'd1);
`else
            chk("r7_drain_busy", {31'd0, rd_busy[0]}, 32'd1);
`endif
            edge_step();
        end
        wr_en = 1'b0;
        settle();
        chk("r7_clear", {31'd0, rd_busy[0]}, 32'd0);
        edge_step();

        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00009999; rd_addr = {5'd0, 5'd9};
        edge_step();
        wr_en = 1'b0;
        settle();
        chk("r9_data", rd_data[31:0], 32'h00009999);
        chk("r9_not_busy", {31'd0, rd_busy[0]}, 32'd0);
        edge_step();
        iss_en = 1'b1; iss_addr = 5'd9;
        settle();
        chk("r9_busy_same_cycle", {31'd0, rd_busy[0]}, 32'd0);
        edge_step();
        iss_en = 1'b0;
        settle();
        chk("r9_busy_next", {31'd0, rd_busy[0]}, 32'd1);
        edge_step();

        iss_en = 1'b1; iss_addr = 5'd3;
        edge_step();
        iss_addr = 5'd4;
        edge_step();
        iss_en = 1'b0;
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFFFFFF;
        edge_step();
        reset = 1'b0; wr_en = 1'b0; rd_addr = {5'd4, 5'd3};
        iss_en = 1'b1; iss_addr = 5'd3;
        settle();
        chk("rst_r3_data", rd_data[31:0], 32'd0);
        chk("rst_busy", {30'd0, rd_busy}, 32'd0);
        chk("rst_iss_ok", {31'd0, iss_ok}, 32'd1);
        iss_en = 1'b0; rd_addr = {5'd5, 5'd9};
        #1;
        chk("rst_r9_busy", {31'd0, rd_busy[0]}, 32'd0);
        chk("rst_r5_data", rd_data[63:32], 32'd0);
        edge_step();

        for (int i = 0; i < 300; i++) begin
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = pick_addr(int'($urandom_range(0, 3)));
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = pick_addr(int'($urandom_range(0, 3)));
            wr_data  = $urandom;
            rd_addr  = {pick_addr(int'($urandom_range(0, 3))), pick_addr(int'($urandom_range(0, 3)))};
            reset    = ($urandom_range(0, 79) == 0);
            settle();
            edge_step();
        end
        reset = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
        edge_step();

        wr_en2 = 1'b1; wr_addr2 = 5'd1; wr_data2 = 16'h1111;
        edge_step();
        wr_addr2 = 5'd2; wr_data2 = 16'h2222;
        edge_step();
        wr_en2 = 1'b0; rd_addr2 = {5'd1, 5'd2, 5'd1};
        settle();
        chk("p3_port0", {16'd0, rd_data2[15:0]}, 32'h1111);
        chk("p3_port1", {16'd0, rd_data2[31:16]}, 32'h2222);
        chk("p3_port2", {16'd0, rd_data2[47:32]}, 32'h1111);
        chk("p3_busy", {29'd0, rd_busy2}, 32'd0);
        edge_step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
